wave_frame_scanner: RTL and testbench
=====================================

Name: wave_frame_scanner

Overview:
- Downstream readout stage for the wave mesh: sweeps the mesh read port after every frame commit and streams |Ψ|² in raster order over a valid/ready stream to the visualization/DMA path.
- Also reduces each frame to a norm sum (total probability) and a peak magnitude with its coordinates, for host-side drift/stability monitoring.

Parameters:
MESH_X, 8, mesh width in sites (≥2)
MESH_Y, 8, mesh height in sites (≥2)
PSI_WIDTH, 16, width of the |Ψ|² magnitude
SUM_WIDTH, PSI_WIDTH+$clog2(MESH_X*MESH_Y), norm accumulator width (never overflows)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
frame_done  in  1  one-cycle pulse from mesh on buffer commit
read_x  out  $clog2(MESH_X)  mesh read address X
read_y  out  $clog2(MESH_Y)  mesh read address Y
read_magnitude  in  PSI_WIDTH  |Ψ|² at (read_x,read_y), combinational from the mesh, same cycle
m_valid  out  1  stream beat valid
m_ready  in  1  downstream ready
m_data  out  PSI_WIDTH  magnitude sample
m_x  out  $clog2(MESH_X)  sample X coordinate
m_y  out  $clog2(MESH_Y)  sample Y coordinate
m_last  out  1  high on final beat of frame (x=MESH_X-1, y=MESH_Y-1)
scan_active  out  1  high from SCAN entry until last beat accepted
norm_sum  out  SUM_WIDTH  sum of all magnitudes of last completed frame
peak_val  out  PSI_WIDTH  max magnitude of last completed frame
peak_x  out  $clog2(MESH_X)  X of peak
peak_y  out  $clog2(MESH_Y)  Y of peak
stats_valid  out  1  one-cycle pulse when norm/peak outputs update
overrun  out  1  sticky: frame_done arrived while scanning
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, state IDLE, read_x=read_y=0, internal accumulators 0. Reset mid-scan aborts; m_valid low from the next cycle, no stats_valid.
- States: IDLE -> SCAN on frame_done; SCAN -> DRAIN after capturing the last site; DRAIN -> IDLE when last beat accepted (m_valid&&m_ready&&m_last).
- SCAN capture condition: (!m_valid || m_ready). On capture: m_data<=read_magnitude, m_x/m_y<=read_x/read_y, m_last set if last site, m_valid<=1, address advances (x fastest, y outer row-major), accumulators update. No capture -> address and output held (backpressure).
- Output register holds its value while m_valid&&!m_ready; m_valid drops after acceptance only when no new capture happens in the same cycle.
- Latency: frame_done at cycle T -> SCAN at T+1 with address (0,0) -> first beat visible T+2. With m_ready held high, one beat per cycle, last beat at T+1+MESH_X*MESH_Y.
- Accumulation: sum starts at 0 on SCAN entry, adds each captured sample, zero-extended. Peak starts at first sample; updated only on strictly greater value (ties keep earliest raster position).
- On DRAIN->IDLE transition: norm_sum/peak_val/peak_x/peak_y load the accumulators, stats_valid pulses high one cycle later together with the new values. They hold until the next frame completes.
- read_x/read_y return to 0 in IDLE.
- frame_done while in SCAN or DRAIN: ignored (no restart), overrun<=1. frame_done and clr_overrun in the same cycle: set wins. frame_done on the same cycle as DRAIN->IDLE is treated as overrun, not a new scan.
- scan_active = (state != IDLE).

Test Plan:
- 8x8 mesh, magnitudes = x+8y, m_ready=1, frame_done pulse at T -> 64 beats T+2..T+65, m_data 0..63 in order, m_last only on beat 63, norm_sum=2016, peak_val=63 at (7,7), stats_valid pulse once.
- Same data, m_ready toggled 1/0 every cycle -> identical beat sequence, no loss/duplication, m_data stable while stalled, stats identical.
- All sites=5 except (3,2)=9 and (6,6)=9 -> peak_val=9, peak_x=3, peak_y=2, norm_sum=5*62+18=328.
- Extra frame_done 10 cycles into scan -> scan finishes normally (64 beats), overrun=1 until clr_overrun pulse, then 0; simultaneous frame_done+clr_overrun -> overrun stays 1.
- rst_n low for one cycle at beat 20 -> m_valid=0, scan_active=0, all outputs 0 next cycle, no stats_valid; next frame_done scans cleanly from (0,0).
- All magnitudes 0xFFFF -> norm_sum=0x3FFFC0 (64*65535, 22-bit), no overflow.

Source files
------------

// File: rtl/wave_frame_scanner.sv
// wave_frame_scanner: sweeps the mesh read port after each frame commit,
// streams |psi|^2 in raster order over valid/ready, and reduces every frame
// to a norm sum plus a peak magnitude with its coordinates.
module wave_frame_scanner #(
    parameter int MESH_X    = 8,
    parameter int MESH_Y    = 8,
    parameter int PSI_WIDTH = 16,
    parameter int SUM_WIDTH = PSI_WIDTH + $clog2(MESH_X * MESH_Y)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_done,
    output logic [$clog2(MESH_X)-1:0]   read_x,
    output logic [$clog2(MESH_Y)-1:0]   read_y,
    input  logic [PSI_WIDTH-1:0]        read_magnitude,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [PSI_WIDTH-1:0]        m_data,
    output logic [$clog2(MESH_X)-1:0]   m_x,
    output logic [$clog2(MESH_Y)-1:0]   m_y,
    output logic                        m_last,
    output logic                        scan_active,
    output logic [SUM_WIDTH-1:0]        norm_sum,
    output logic [PSI_WIDTH-1:0]        peak_val,
    output logic [$clog2(MESH_X)-1:0]   peak_x,
    output logic [$clog2(MESH_Y)-1:0]   peak_y,
    output logic                        stats_valid,
    output logic                        overrun,
    input  logic                        clr_overrun
);

    localparam int XW = $clog2(MESH_X);
    localparam int YW = $clog2(MESH_Y);
    localparam logic [XW-1:0] X_LAST = XW'(MESH_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(MESH_Y - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q;
    logic [XW-1:0]          rd_x_q;
    logic [YW-1:0]          rd_y_q;
    logic                   m_valid_q;
    logic [PSI_WIDTH-1:0]   m_data_q;
    logic [XW-1:0]          m_x_q;
    logic [YW-1:0]          m_y_q;
    logic                   m_last_q;
    logic [SUM_WIDTH-1:0]   sum_q;
    logic [PSI_WIDTH-1:0]   pk_q;
    logic [XW-1:0]          pk_x_q;
    logic [YW-1:0]          pk_y_q;
    logic [SUM_WIDTH-1:0]   norm_sum_q;
    logic [PSI_WIDTH-1:0]   peak_val_q;
    logic [XW-1:0]          peak_x_q;
    logic [YW-1:0]          peak_y_q;
    logic                   stats_valid_q;
    logic                   overrun_q;

    logic                   is_first;
    logic                   is_last;
    logic                   capture;
    logic                   peak_take;
    logic                   last_accept;
    logic [SUM_WIDTH-1:0]   sum_d;

    // Capture qualification and next accumulator values for the current site.
    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        is_first    = 1'b0;
        is_last     = 1'b0;
        capture     = 1'b0;
        peak_take   = 1'b0;
        last_accept = 1'b0;
        sum_d       = '0;

        is_first    = (rd_x_q == '0) && (rd_y_q == '0);
        is_last     = (rd_x_q == X_LAST) && (rd_y_q == Y_LAST);
        capture     = (state_q == SCAN) && (!m_valid_q || m_ready);
        // The first site restarts the frame: the sum starts from zero and the
        // peak is seeded; afterwards only a strictly larger value moves the peak.
        sum_d       = (is_first ? '0 : sum_q) + SUM_WIDTH'(read_magnitude);
        peak_take   = is_first || (read_magnitude > pk_q);
        last_accept = m_valid_q && m_ready && m_last_q;
    end

    // Scan FSM, output beat register, frame reduction and overrun flag.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_x_q        <= '0;
            rd_y_q        <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_x_q         <= '0;
            m_y_q         <= '0;
            m_last_q      <= 1'b0;
            sum_q         <= '0;
            pk_q          <= '0;
            pk_x_q        <= '0;
            pk_y_q        <= '0;
            norm_sum_q    <= '0;
            peak_val_q    <= '0;
            peak_x_q      <= '0;
            peak_y_q      <= '0;
            stats_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            stats_valid_q <= 1'b0;

            // A commit while busy is dropped but remembered; set beats clear.
            if (frame_done && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end

            // An accepted beat retires unless a capture below refills it.
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    rd_x_q <= '0;
                    rd_y_q <= '0;
                    if (frame_done) begin
                        state_q <= SCAN;
                    end
                end

                SCAN: begin
                    if (capture) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= read_magnitude;
                        m_x_q     <= rd_x_q;
                        m_y_q     <= rd_y_q;
                        m_last_q  <= is_last;
                        sum_q     <= sum_d;
                        if (peak_take) begin
                            pk_q   <= read_magnitude;
                            pk_x_q <= rd_x_q;
                            pk_y_q <= rd_y_q;
                        end
                        if (is_last) begin
                            rd_x_q  <= '0;
                            rd_y_q  <= '0;
                            state_q <= DRAIN;
                        end else if (rd_x_q == X_LAST) begin
                            rd_x_q <= '0;
                            rd_y_q <= rd_y_q + Y_ONE;
                        end else begin
                            rd_x_q <= rd_x_q + X_ONE;
                        end
                    end
                end

                DRAIN: begin
                    if (last_accept) begin
                        state_q       <= IDLE;
                        norm_sum_q    <= sum_q;
                        peak_val_q    <= pk_q;
                        peak_x_q      <= pk_x_q;
                        peak_y_q      <= pk_y_q;
                        stats_valid_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_x      = rd_x_q;
    assign read_y      = rd_y_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_x         = m_x_q;
    assign m_y         = m_y_q;
    assign m_last      = m_last_q;
    assign scan_active = (state_q != IDLE);
    assign norm_sum    = norm_sum_q;
    assign peak_val    = peak_val_q;
    assign peak_x      = peak_x_q;
    assign peak_y      = peak_y_q;
    assign stats_valid = stats_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_wave_frame_scanner.sv
// Scoreboard bench for wave_frame_scanner: each accepted frame commit pushes
// the expected raster beats and frame statistics into queues; an independent
// monitor pops and compares whenever the DUT presents a beat or stats pulse.
module tb_wave_frame_scanner;

    localparam int MX = 8;
    localparam int MY = 8;
    localparam int PW = 16;
    localparam int SW = PW + $clog2(MX * MY);

    typedef struct {
        logic [PW-1:0] data;
        logic [2:0]    x;
        logic [2:0]    y;
        logic          last;
    } beat_t;

    typedef struct {
        logic [SW-1:0] sum;
        logic [PW-1:0] pk;
        logic [2:0]    px;
        logic [2:0]    py;
    } stats_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_done = 1'b0;
    logic          m_ready = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [2:0]    read_x, read_y, m_x, m_y, peak_x, peak_y;
    logic [PW-1:0] read_magnitude, m_data, peak_val;
    logic          m_valid, m_last, scan_active, stats_valid, overrun;
    logic [SW-1:0] norm_sum;

    logic [PW-1:0] mesh [MY][MX];
    assign read_magnitude = mesh[read_y][read_x];

    beat_t  beat_q[$];
    stats_t stats_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    int beat_cnt = 0;
    int stats_cnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int frame_t = 0;

    logic  stalled = 1'b0;
    beat_t prev_beat;

    wave_frame_scanner #(
        .MESH_X(MX), .MESH_Y(MY), .PSI_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_done(frame_done),
        .read_x(read_x), .read_y(read_y), .read_magnitude(read_magnitude),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_x(m_x), .m_y(m_y), .m_last(m_last), .scan_active(scan_active),
        .norm_sum(norm_sum), .peak_val(peak_val), .peak_x(peak_x), .peak_y(peak_y),
        .stats_valid(stats_valid), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares beats and stats pulses against the scoreboard queues.
    initial begin
        beat_t  eb;
        stats_t es;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid_held", 64'(m_valid), 64'd1);
                    check("stall_beat_held", {m_data, m_x, m_y, m_last},
                          {prev_beat.data, prev_beat.x, prev_beat.y, prev_beat.last});
                end
                if (m_valid && m_ready) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        eb = beat_q.pop_front();
                        check("beat_data", 64'(m_data), 64'(eb.data));
                        check("beat_xy", {m_x, m_y}, {eb.x, eb.y});
                        check("beat_last", 64'(m_last), 64'(eb.last));
                        if (eb.x == 3'd0 && eb.y == 3'd0) first_cyc = cyc;
                        if (eb.last) last_cyc = cyc;
                        beat_cnt++;
                    end
                end
                stalled = m_valid && !m_ready;
                prev_beat.data = m_data;
                prev_beat.x    = m_x;
                prev_beat.y    = m_y;
                prev_beat.last = m_last;
                if (stats_valid) begin
                    stats_cnt++;
                    if (stats_q.size() == 0) begin
                        check("unexpected_stats_valid", 64'd1, 64'd0);
                    end else begin
                        es = stats_q.pop_front();
                        check("norm_sum", 64'(norm_sum), 64'(es.sum));
                        check("peak_val", 64'(peak_val), 64'(es.pk));
                        check("peak_xy", {peak_x, peak_y}, {es.px, es.py});
                    end
                end
            end
        end
    end

    // Reference model: a committed frame is read out in raster order; the
    // sum is the plain total and the peak is the first strict maximum.
    task automatic model_frame();
        beat_t  b;
        stats_t s;
        s.sum = '0;
        s.pk  = '0;
        s.px  = '0;
        s.py  = '0;
        for (int y = 0; y < MY; y++) begin
            for (int x = 0; x < MX; x++) begin
                b.data = mesh[y][x];
                b.x    = 3'(x);
                b.y    = 3'(y);
                b.last = (x == MX - 1) && (y == MY - 1);
                beat_q.push_back(b);
                s.sum = s.sum + SW'(mesh[y][x]);
                if ((x == 0 && y == 0) || mesh[y][x] > s.pk) begin
                    s.pk = mesh[y][x];
                    s.px = 3'(x);
                    s.py = 3'(y);
                end
            end
        end
        stats_q.push_back(s);
    endtask

    task automatic frame_pulse(input bit expect_scan);
        @(posedge clk);
        #1;
        frame_done = 1'b1;
        if (expect_scan) begin
            model_frame();
            frame_t   = cyc;
            beat_cnt  = 0;
            stats_cnt = 0;
        end
        @(posedge clk);
        #1;
        frame_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (!scan_active && beat_q.size() == 0 && stats_q.size() == 0) done = 1'b1;
        end
        check("wait_idle_in_budget", 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_scan_active"}, 64'(scan_active), 64'd0);
        check({tag, "_m_beat"}, {m_data, m_x, m_y, m_last}, 64'd0);
        check({tag, "_read_xy"}, {read_x, read_y}, 64'd0);
        check({tag, "_stats"}, {norm_sum, peak_val, peak_x, peak_y}, 64'd0);
        check({tag, "_flags"}, {stats_valid, overrun}, 64'd0);
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < MY; y++)
            for (int x = 0; x < MX; x++)
                mesh[y][x] = PW'(x + MX * y);
    endtask

    task automatic fill_const(input logic [PW-1:0] v);
        for (int y = 0; y < MY; y++)
            for (int x = 0; x < MX; x++)
                mesh[y][x] = v;
    endtask

    task automatic check_frame_counts(input string tag);
        check({tag, "_beats"}, 64'(beat_cnt), 64'd64);
        check({tag, "_stats_pulses"}, 64'(stats_cnt), 64'd1);
    endtask

    initial begin
        fill_ramp();

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ramp frame, always ready: latency and throughput.
        ready_mode = 0;
        frame_pulse(1);
        wait_idle(300);
        check_frame_counts("ramp");
        check("ramp_first_beat_cycle", 64'(first_cyc), 64'(frame_t + 2));
        check("ramp_last_beat_cycle", 64'(last_cyc), 64'(frame_t + 65));
        check("ramp_norm_const", 64'(norm_sum), 64'd2016);
        check("ramp_peak_const", {peak_val, peak_x, peak_y}, {16'd63, 3'd7, 3'd7});

        // Same ramp with ready toggling every cycle.
        ready_mode = 1;
        frame_pulse(1);
        wait_idle(400);
        check_frame_counts("toggle");
        check("toggle_norm_const", 64'(norm_sum), 64'd2016);

        // Tied peaks: earliest raster position wins.
        fill_const(16'd5);
        mesh[2][3] = 16'd9;
        mesh[6][6] = 16'd9;
        ready_mode = 2;
        frame_pulse(1);
        wait_idle(600);
        check_frame_counts("tie");
        check("tie_norm_const", 64'(norm_sum), 64'd328);
        check("tie_peak_const", {peak_val, peak_x, peak_y}, {16'd9, 3'd3, 3'd2});

        // Overrun: extra commit mid-scan is ignored but flagged.
        fill_ramp();
        ready_mode = 1;
        frame_pulse(1);
        repeat (10) @(posedge clk);
        frame_pulse(0);
        check("overrun_set", 64'(overrun), 64'd1);
        wait_idle(400);
        check_frame_counts("overrun_frame");
        check("overrun_sticky", 64'(overrun), 64'd1);
        @(posedge clk); #1; clr_overrun = 1'b1;
        @(posedge clk); #1; clr_overrun = 1'b0;
        check("overrun_cleared", 64'(overrun), 64'd0);
        frame_pulse(1);
        repeat (5) @(posedge clk);
        #1;
        frame_done = 1'b1;
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        clr_overrun = 1'b0;
        check("overrun_set_beats_clear", 64'(overrun), 64'd1);
        wait_idle(400);
        check_frame_counts("overrun_frame2");
        @(posedge clk); #1; clr_overrun = 1'b1;
        @(posedge clk); #1; clr_overrun = 1'b0;
        check("overrun_cleared2", 64'(overrun), 64'd0);

        // Reset at beat 20 aborts the scan with no stats pulse.
        ready_mode = 0;
        frame_pulse(1);
        for (int i = 0; i < 200 && beat_cnt < 20; i++) begin
            @(posedge clk);
            #1;
        end
        check("abort_reached_beat20", 64'(beat_cnt), 64'd20);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat_q.delete();
        stats_q.delete();
        check_all_zero("abort");
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_stats_pulse", 64'(stats_cnt), 64'd0);
        frame_pulse(1);
        wait_idle(300);
        check_frame_counts("post_abort");
        check("post_abort_first_cycle", 64'(first_cyc), 64'(frame_t + 2));

        // Saturated magnitudes: full-width sum without overflow.
        fill_const(16'hFFFF);
        ready_mode = 2;
        frame_pulse(1);
        wait_idle(600);
        check_frame_counts("sat");
        check("sat_norm_const", 64'(norm_sum), 64'h3FFFC0);

        // Random frames under random backpressure.
        for (int f = 0; f < 2; f++) begin
            for (int y = 0; y < MY; y++)
                for (int x = 0; x < MX; x++)
                    mesh[y][x] = PW'($urandom_range(0, 65535));
            frame_pulse(1);
            wait_idle(600);
            check_frame_counts("random");
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_beats_drained", 64'(beat_q.size()), 64'd0);
        check("scoreboard_stats_drained", 64'(stats_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
